// File: rtl/ul_pkg.sv
// Shared definitions for the bit-serial logic unit: op-code encodings and FSM state type.
package ul_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cl_slice.sv
// Combinational bitwise op on one SLICE-wide chunk of the operands.
module cl_slice
  import ul_pkg::*;
#(
  parameter int SLICE = 2
) (
  output logic [SLICE-1:0] Y,
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic [1:0]       S
);

  always_comb begin
    Y = '0;
    case (S)
      OP_AND:  Y = A & B;
      OP_OR:   Y = A | B;
      OP_XOR:  Y = A ^ B;
      default: Y = ~A;
    endcase
  end

endmodule

// File: rtl/ul_serie.sv
// Bit-serial logic unit: computes one SLICE-wide chunk per cycle, publishing Out/zero
// only when the last chunk completes.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | processing slice r_cnt of the latched operands
//   DONE  | one-cycle completion; start here chains the next operation
module ul_serie
  import ul_pkg::*;
#(
  parameter int W     = 8,
  parameter int SLICE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [1:0]   S,
  input  logic         acc_en,
  output logic [W-1:0] Out,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  localparam int N  = W / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;
  logic            r_acc;
  logic [W-1:0]    r_res;

  logic            w_accept;
  logic            w_last;
  logic [W-1:0]    w_b_opnd;
  logic [SLICE-1:0] w_a_slc;
  logic [SLICE-1:0] w_b_slc;
  logic [SLICE-1:0] w_y;
  logic [W-1:0]    w_res_nxt;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == CW'(N - 1));
  // Out is frozen during RUN, so selecting it here equals its value at acceptance.
  assign w_b_opnd = r_acc ? Out : r_b;

  always_comb begin
    w_a_slc   = '0;
    w_b_slc   = '0;
    w_res_nxt = r_res;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_slc = r_a[k*SLICE +: SLICE];
        w_b_slc = w_b_opnd[k*SLICE +: SLICE];
        w_res_nxt[k*SLICE +: SLICE] = w_y;
      end
    end
  end

  cl_slice #(.SLICE(SLICE)) u_slice (
    .Y (w_y),
    .A (w_a_slc),
    .B (w_b_slc),
    .S (r_op)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= OP_AND;
      r_acc <= 1'b0;
      r_res <= '0;
      Out   <= '0;
      zero  <= 1'b1;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_a   <= A;
      r_b   <= B;
      r_op  <= S;
      r_acc <= acc_en;
    end else if (r_state == RUN) begin
      r_res <= w_res_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        Out  <= w_res_nxt;
        zero <= (w_res_nxt == '0);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: doc/ul_serie.md
UL_SERIE -- requirements
Module: ul_serie

Interface
REQ-001 Parameter W, default 8: operand/result width in bits; SHALL be a multiple of SLICE and at least SLICE.
REQ-002 Parameter SLICE, default 2: bits processed per cycle; number of slices N = W/SLICE.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request to begin one operation.
REQ-006 Port A, input, W: operand A.
REQ-007 Port B, input, W: operand B.
REQ-008 Port S, input, 2: op select; 00 AND, 01 OR, 10 XOR, 11 NOT A.
REQ-009 Port acc_en, input, 1: accumulate mode; replaces B with the current Out.
REQ-010 Port Out, output, W: registered result of the last completed operation.
REQ-011 Port zero, output, 1: registered flag, 1 when the last completed result is all zeros.
REQ-012 Port busy, output, 1: 1 while an operation is in progress.
REQ-013 Port done, output, 1: one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 Start acceptance: start=1 at a rising edge in IDLE or DONE SHALL latch A, B (or Out when acc_en=1), S and acc_en, clear the slice counter, and enter RUN.
REQ-016 Start SHALL be ignored in RUN; in RUN, changes on A, B, S and acc_en SHALL have no effect on the operation in progress.
REQ-017 Each RUN cycle SHALL compute slice k (bits k*SLICE+SLICE-1..k*SLICE) into an internal result register using the latched S, for k = 0..N-1 in ascending order.
REQ-018 On the edge that completes slice N-1, Out and zero SHALL update together and the FSM SHALL enter DONE; Out SHALL NOT change at any other time except reset.
REQ-019 Latency: with start sampled at edge t, done SHALL be 1 during the cycle after edge t+N, and 0 otherwise.
REQ-020 busy SHALL be 1 exactly while in RUN.
REQ-021 DONE SHALL last one cycle: it moves to RUN if start=1, otherwise to IDLE, which allows back-to-back operations every N+1 cycles.
REQ-022 S=11 SHALL produce bitwise NOT of A; B and acc_en SHALL have no effect on the result.
REQ-023 Accumulate operand: with acc_en=1, the operand used in place of B SHALL be the value of Out at the start-acceptance edge.
REQ-024 Width rules: all operations are bitwise, so there is no carry, overflow or sign handling; the slice counter SHALL be ceil(log2(N)) bits wide, minimum 1 bit.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, Out=0, zero=1, busy=0, done=0, and clear the counter and latched operands.
REQ-026 Reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse and no Out update.

Structure
REQ-027 A shared package ul_pkg SHALL hold the op-code constants (OP_AND, OP_OR, OP_XOR, OP_NOT) and the FSM state type.
REQ-028 A sub-module cl_slice (parameter SLICE; ports Y, A, B, S) SHALL implement the combinational per-slice op.
REQ-029 ul_serie SHALL instantiate cl_slice once and multiplex the active slice into it by counter index.

Verification (W=8, SLICE=2)
REQ-030 Reset then idle: after reset, Out=00h, zero=1, busy=0, done=0; start=0 for 10 cycles leaves all outputs unchanged.
REQ-031 Single op and latency: A=C3h, B=A5h, S=10 (XOR), start sampled at edge 0 -> busy=1 for 4 cycles; Out=66h and done=1 only in the cycle after edge 4; zero=0.
REQ-032 Op coverage: the same A/B with S=00, 01 and 11 -> Out=81h, E7h and 3Ch respectively; A=0Fh, B=F0h, S=00 -> Out=00h, zero=1.
REQ-033 Accumulate: Out=F0h, then A=3Ch, S=10, acc_en=1 -> Out=CCh; start again with A=CCh, S=10, acc_en=1 -> Out=00h, zero=1.
REQ-034 Busy/back-to-back: start held high and operands changed mid-RUN -> first result unaffected; a second operation is accepted in DONE, giving done pulses 5 cycles apart.
REQ-035 Reset mid-operation: reset asserted at edge 2 of a RUN -> IDLE, Out=00h, no done pulse; the next start completes normally.
